// File: rtl/cacheline_burst_adaptor_if.sv
// cacheline_burst_adaptor_if: request/response bus; W=256 on the cache side, W=64 on the memory side.
interface cacheline_burst_adaptor_if #(parameter int W = 256);
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    logic [31:0] addr;
    logic read;
    logic write;
    logic resp;
    modport master(output wdata, addr, read, write, input rdata, resp);
    modport slave(input wdata, addr, read, write, output rdata, resp);
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: turns one 256-bit line request into four 64-bit memory beats.
// Define CLA_RESP_BYPASS_EN to drop the DONE state and signal completion alongside the last beat.
module cacheline_burst_adaptor (
    input logic clk,
    input logic rst,
    cacheline_burst_adaptor_if.slave cache,
    cacheline_burst_adaptor_if.master mem
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
`ifdef CLA_RESP_BYPASS_EN
    localparam state_t AFTER = IDLE;
`else
    localparam state_t AFTER = DONE;
`endif
    state_t state, next;
    logic [1:0] cnt;
    logic [255:0] buffer, wbuf;
    logic [31:0] addr;
    logic busy, last;
    assign busy = state == READ || state == WRITE;
    assign last = busy && mem.resp && cnt == 2'd3;
    always_ff @(posedge clk) state <= rst ? IDLE : next;
    // read wins when the cache raises both requests together
    always_comb next = state == IDLE ? (cache.read ? READ : cache.write ? WRITE : IDLE)
                                     : busy ? (last ? AFTER : state) : IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            buffer <= '0;
            wbuf <= '0;
            addr <= '0;
        end else if (state == IDLE && (cache.read || cache.write)) begin
            cnt <= '0;
            addr <= cache.addr;
            if (!cache.read) wbuf <= cache.wdata;
        end else if (busy && mem.resp) begin
            cnt <= cnt + 2'd1;
            if (state == READ) buffer[64*cnt +: 64] <= mem.rdata;
        end
    end
    always_comb begin
        mem.addr = addr & ~32'h1f;
        mem.read = state == READ;
        mem.write = state == WRITE;
        mem.wdata = state == WRITE ? wbuf[64*cnt +: 64] : '0;
`ifdef CLA_RESP_BYPASS_EN
        cache.resp = last;
        cache.rdata = last && state == READ ? {mem.rdata, buffer[191:0]} : buffer;
`else
        cache.resp = state == DONE;
        cache.rdata = buffer;
`endif
    end
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb_cacheline_burst_adaptor: scoreboard bench covering reads, stalled writes, reset mid-burst and back-to-back lines.
`timescale 1ns/1ps
module tb_cacheline_burst_adaptor;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    cacheline_burst_adaptor_if #(.W(256)) cache ();
    cacheline_burst_adaptor_if #(.W(64)) mem ();
    cacheline_burst_adaptor dut (.clk(clk), .rst(rst), .cache(cache), .mem(mem));
`ifdef CLA_RESP_BYPASS_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 5;
`endif
    logic [255:0] resp_q[$];
    logic [63:0] beat_q[$];
    logic [255:0] rd_line = '0;
    logic [255:0] last_line = '0;
    logic [31:0] exp_addr = '0;
    logic [1:0] mbeat = '0;
    bit macc, mrst, tog, stall, saw_write;
    int n_pass = 0, n_total = 0, n_resp = 0, resp_cyc = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // memory model: acknowledges every cycle, or every other cycle when stalling
    initial begin
        mem.resp = 0;
        mem.rdata = '0;
        forever begin
            @(negedge clk);
            macc = (mem.read || mem.write) && mem.resp;
            mrst = rst;
            @(posedge clk);
            #1;
            mbeat = mrst ? 2'd0 : mbeat + 2'(macc);
            tog = !tog;
            mem.resp = stall ? tog : 1'b1;
            mem.rdata = rd_line[64*mbeat +: 64];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem.read || mem.write) begin
                check("addr", mem.addr, exp_addr);
                check("rw_excl", mem.read && mem.write, 0);
            end
            if (mem.write) begin
                saw_write = 1;
                if (beat_q.size() == 0) check("beat_extra", mem.write, 0);
                else if (mem.resp) check("beat", mem.wdata, beat_q.pop_front());
                else check("beat_hold", mem.wdata, beat_q[0]);
            end
            if (cache.resp) begin
                n_resp++;
                resp_cyc = cyc;
                if (resp_q.size() == 0) check("resp_extra", cache.resp, 0);
                else check("line", cache.rdata, resp_q.pop_front());
            end
        end
    end

    task automatic run(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] line, output int lat);
        int got = n_resp;
        int start = cyc;
        cache.addr = a;
        cache.wdata = line;
        cache.read = rd;
        cache.write = wr;
        exp_addr = a & ~32'h1f;
        if (rd) begin
            rd_line = line;
            last_line = line;
            resp_q.push_back(line);
        end else begin
            resp_q.push_back(last_line);
            for (int i = 0; i < 4; i++) beat_q.push_back(line[64*i +: 64]);
        end
        for (int k = 0; k < 40 && n_resp == got; k++) @(posedge clk);
        check("resp_seen", n_resp - got, 1);
        lat = resp_cyc - start;
    endtask

    task automatic drop();
        #1;
        cache.read = 0;
        cache.write = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        cache.read = 0;
        cache.write = 0;
        cache.addr = '0;
        cache.wdata = '0;
        stall = 0;
        saw_write = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_read", mem.read, 0);
        check("rst_write", mem.write, 0);
        check("rst_resp", cache.resp, 0);
        check("rst_addr", mem.addr, 0);
        check("rst_line", cache.rdata, 0);
        check("rst_wdata", mem.wdata, 0);
        @(posedge clk);
        #1 rst = 0;
        stall = 1;
        repeat (4) begin
            @(negedge clk);
            check("idle_read", mem.read, 0);
            check("idle_resp", cache.resp, 0);
        end
        stall = 0;
        @(posedge clk);
        #1;
        run(1, 0, 32'h0000_1234, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, lat);
        check("rd_lat", lat, LAT);
        drop();
        stall = 1;
        run(0, 1, 32'h0000_2040, {64'hD, 64'hC, 64'hB, 64'hA}, lat);
        stall = 0;
        check("wr_beats_left", beat_q.size(), 0);
        drop();
        saw_write = 0;
        run(1, 1, 32'h0000_3010, {64'h0123_4567_89ab_cdef, 64'hfeed_face_dead_beef, 64'h5a5a_a5a5_0f0f_f0f0, 64'h1111_2222_3333_4444}, lat);
        check("both_lat", lat, LAT);
        check("both_no_write", saw_write, 0);
        drop();
        cache.addr = 32'h0000_5060;
        cache.read = 1;
        exp_addr = 32'h0000_5060;
        rd_line = {64'h9999, 64'h8888, 64'h7777, 64'h6666};
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        cache.read = 0;
        @(posedge clk);
        #1 rst = 0;
        last_line = '0;
        @(negedge clk);
        check("mid_rst_read", mem.read, 0);
        check("mid_rst_line", cache.rdata, 0);
        check("mid_rst_resp", cache.resp, 0);
        check("mid_rst_addr", mem.addr, 0);
        @(posedge clk);
        #1;
        run(1, 0, 32'h4444_0008, {64'hAAAA_0003, 64'hAAAA_0002, 64'hAAAA_0001, 64'hAAAA_0000}, lat);
        check("fresh_lat", lat, LAT);
        drop();
        run(0, 1, 32'h0000_7000, {64'hB3, 64'hB2, 64'hB1, 64'hB0}, lat);
        check("b2b_wr_lat", lat, LAT);
        #1;
        run(1, 0, 32'h0000_8020, {64'hC3, 64'hC2, 64'hC1, 64'hC0}, lat);
        check("b2b_rd_lat", lat, LAT);
        drop();
        repeat (3) @(posedge clk);
        check("resp_left", resp_q.size(), 0);
        check("beats_left", beat_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
